// File: rtl/eq_pkg.sv
// Shared constants and types for the EQ band mixer.
//   NUM_BANDS_MAX  largest supported band count
//   UNITY_GAIN     Q2.14 value of 1.0
//   ROUND_SHIFT    accumulator-to-output alignment shift
//   *_W            datapath widths
//   eq_state_e     sequencer states
package eq_pkg;

   localparam int unsigned NUM_BANDS_MAX = 16;
   localparam int unsigned BAND_W        = 48;
   localparam int unsigned OPND_W        = 32;
   localparam int unsigned GAIN_W        = 16;
   localparam int unsigned PROD_W        = 48;
   localparam int unsigned ACC_W         = 52;
   localparam int unsigned OUT_W         = 24;
   localparam int unsigned ROUND_SHIFT   = 13;

   localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h4000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } eq_state_e;

endpackage

// File: rtl/eq_mac_lane.sv
// One channel's multiply-accumulate with round-half-up and saturation.
//   clk, reset_n  clock, async active-low reset
//   acc_clr       clear the accumulator (snapshot or abort)
//   mac_en        add operand*gain into the accumulator this clock
//   operand       signed band operand (band[47:16])
//   gain          signed Q2.14 shadow gain
//   result_c      rounded, saturated accumulator (combinational)
//   clip_c        result_c was clipped (combinational)
module eq_mac_lane
   import eq_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     acc_clr,
   input  logic                     mac_en,
   input  logic signed [OPND_W-1:0] operand,
   input  logic signed [GAIN_W-1:0] gain,
   output logic signed [OUT_W-1:0]  result_c,
   output logic                     clip_c
);

   localparam int unsigned SH_W = ACC_W + 1 - ROUND_SHIFT;
   localparam int unsigned HI_W = SH_W - OUT_W + 1;
   localparam logic [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(1) << (ROUND_SHIFT - 1);
   localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W:0]    biased_c;
   logic signed [SH_W-1:0]   shifted_c;
   logic [HI_W-1:0]          hi_c;

   // Product, rounding bias (one extra bit so the bias can never wrap), shift, clip
   always_comb begin
      prod_c    = PROD_W'(operand) * PROD_W'(gain);
      biased_c  = (ACC_W+1)'(acc) + $signed(ROUND_BIAS);
      shifted_c = SH_W'(biased_c >>> ROUND_SHIFT);
      hi_c      = shifted_c[SH_W-1:OUT_W-1];
      clip_c    = 1'b0;
      result_c  = shifted_c[OUT_W-1:0];
      if (!((&hi_c) || (~|hi_c))) begin
         clip_c   = 1'b1;
         result_c = shifted_c[SH_W-1] ? OUT_MIN : OUT_MAX;
      end
   end

   // Accumulator
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (acc_clr) begin
         acc <= '0;
      end else if (mac_en) begin
         acc <= acc + ACC_W'(prod_c);
      end
   end

endmodule

// File: rtl/eq_band_mixer.sv
// Stereo EQ band mixer: weights each FIR band by a programmable gain, sums
// the bands per channel and rounds/saturates to a Q1.23 sample.
//   clk, reset_n             clock, async active-low reset
//   audio_en                 enable; low aborts to IDLE
//   bands_valid              strobe for l_bands/r_bands
//   l_bands, r_bands         signed Q2.38 band results
//   gain_wr_en/select/data   live gain write port
//   flag_clr                 clear sticky flags
//   l_data_out, r_data_out   mixed Q1.23 samples
//   data_out_valid           one-clock output strobe
//   busy                     sequencer not idle
//   sat_flag, overrun_flag   sticky status
//   test_data                live gain addressed by gain_select
module eq_band_mixer
   import eq_pkg::*;
#(
   parameter int unsigned NUM_BANDS = 4
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                audio_en,
   input  logic                                bands_valid,
   input  logic [NUM_BANDS-1:0][BAND_W-1:0]    l_bands,
   input  logic [NUM_BANDS-1:0][BAND_W-1:0]    r_bands,
   input  logic                                gain_wr_en,
   input  logic [5:0]                          gain_select,
   input  logic [GAIN_W-1:0]                   gain_wr_data,
   input  logic                                flag_clr,
   output logic signed [OUT_W-1:0]             l_data_out,
   output logic signed [OUT_W-1:0]             r_data_out,
   output logic                                data_out_valid,
   output logic                                busy,
   output logic                                sat_flag,
   output logic                                overrun_flag,
   output logic [GAIN_W-1:0]                   test_data
);

   localparam int unsigned IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

   eq_state_e state, nxt;
   logic [IDX_W-1:0]  idx;
   logic [GAIN_W-1:0] gain   [NUM_BANDS];
   logic [GAIN_W-1:0] shadow [NUM_BANDS];
   logic [NUM_BANDS-1:0][OPND_W-1:0] l_snap, r_snap;

   logic accept_c, acc_clr_c, mac_en_c, round_c, sel_ok_c, overrun_set_c;
   logic l_clip_c, r_clip_c, unused_low_c;
   logic signed [OUT_W-1:0] l_res_c, r_res_c;

   // Low 16 fraction bits of each band never reach the multiplier
   always_comb begin
      unused_low_c = 1'b0;
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
         unused_low_c = unused_low_c ^ (^{l_bands[i][BAND_W-OPND_W-1:0],
                                          r_bands[i][BAND_W-OPND_W-1:0]});
      end
   end

   // Sequencer next state and strobes
   always_comb begin
      nxt           = state;
      accept_c      = 1'b0;
      acc_clr_c     = 1'b0;
      mac_en_c      = 1'b0;
      round_c       = 1'b0;
      sel_ok_c      = (gain_select < 6'(NUM_BANDS));
      overrun_set_c = bands_valid && (state != IDLE);
      if (!audio_en) begin
         nxt       = IDLE;
         acc_clr_c = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bands_valid) begin
                  nxt       = MAC;
                  accept_c  = 1'b1;
                  acc_clr_c = 1'b1;
               end
            end
            MAC: begin
               mac_en_c = 1'b1;
               if (idx == LAST_IDX) nxt = ROUND;
            end
            ROUND:   begin
               round_c = 1'b1;
               nxt     = OUT;
            end
            OUT:     nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // State, band index and status
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         idx            <= '0;
         busy           <= 1'b0;
         data_out_valid <= 1'b0;
         l_data_out     <= '0;
         r_data_out     <= '0;
         sat_flag       <= 1'b0;
         overrun_flag   <= 1'b0;
      end else begin
         state          <= nxt;
         idx            <= (state == MAC && nxt == MAC) ? idx + IDX_W'(1) : '0;
         busy           <= (nxt != IDLE);
         data_out_valid <= round_c;
         if (round_c) begin
            l_data_out <= l_res_c;
            r_data_out <= r_res_c;
         end
         // A set event wins over a simultaneous clear
         sat_flag     <= (sat_flag & ~flag_clr) | (round_c & (l_clip_c | r_clip_c));
         overrun_flag <= (overrun_flag & ~flag_clr) | overrun_set_c;
      end
   end

   // Live gains, shadow gains, band snapshot and readback
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_BANDS); i++) begin
            gain[i]   <= UNITY_GAIN;
            shadow[i] <= UNITY_GAIN;
         end
         l_snap    <= '0;
         r_snap    <= '0;
         test_data <= UNITY_GAIN;
      end else begin
         if (gain_wr_en && sel_ok_c) gain[gain_select[IDX_W-1:0]] <= gain_wr_data;
         if (accept_c) begin
            for (int i = 0; i < int'(NUM_BANDS); i++) begin
               shadow[i] <= gain[i];
               l_snap[i] <= l_bands[i][BAND_W-1 -: OPND_W];
               r_snap[i] <= r_bands[i][BAND_W-1 -: OPND_W];
            end
         end
         // Readback reflects a same-clock write so software sees it immediately
         if (!sel_ok_c)       test_data <= '0;
         else if (gain_wr_en) test_data <= gain_wr_data;
         else                 test_data <= gain[gain_select[IDX_W-1:0]];
      end
   end

   eq_mac_lane u_lane_l (
      .clk      (clk),
      .reset_n  (reset_n),
      .acc_clr  (acc_clr_c),
      .mac_en   (mac_en_c),
      .operand  (l_snap[idx]),
      .gain     (shadow[idx]),
      .result_c (l_res_c),
      .clip_c   (l_clip_c)
   );

   eq_mac_lane u_lane_r (
      .clk      (clk),
      .reset_n  (reset_n),
      .acc_clr  (acc_clr_c),
      .mac_en   (mac_en_c),
      .operand  (r_snap[idx]),
      .gain     (shadow[idx]),
      .result_c (r_res_c),
      .clip_c   (r_clip_c)
   );

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer (NUM_BANDS = 4).
module tb_eq_band_mixer;

   localparam int unsigned NB = 4;

   logic                clk;
   logic                reset_n;
   logic                audio_en;
   logic                bands_valid;
   logic [NB-1:0][47:0] l_bands;
   logic [NB-1:0][47:0] r_bands;
   logic                gain_wr_en;
   logic [5:0]          gain_select;
   logic [15:0]         gain_wr_data;
   logic                flag_clr;
   logic [23:0]         l_data_out;
   logic [23:0]         r_data_out;
   logic                data_out_valid;
   logic                busy;
   logic                sat_flag;
   logic                overrun_flag;
   logic [15:0]         test_data;

   eq_band_mixer #(.NUM_BANDS(NB)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .audio_en       (audio_en),
      .bands_valid    (bands_valid),
      .l_bands        (l_bands),
      .r_bands        (r_bands),
      .gain_wr_en     (gain_wr_en),
      .gain_select    (gain_select),
      .gain_wr_data   (gain_wr_data),
      .flag_clr       (flag_clr),
      .l_data_out     (l_data_out),
      .r_data_out     (r_data_out),
      .data_out_valid (data_out_valid),
      .busy           (busy),
      .sat_flag       (sat_flag),
      .overrun_flag   (overrun_flag),
      .test_data      (test_data)
   );

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (data_out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(data_out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("l_data_out", 32'(l_data_out), 32'(e.l));
            chk("r_data_out", 32'(r_data_out), 32'(e.r));
            chk("latency", cnt, e.cyc);
         end
      end
   end

   // Present one sample; expected valid lands 6 clocks after the strobe
   task automatic issue(input logic [NB-1:0][47:0] lb, input logic [NB-1:0][47:0] rb,
                        input bit expect_out, input logic [23:0] el, input logic [23:0] er);
      @(negedge clk);
      l_bands     = lb;
      r_bands     = rb;
      bands_valid = 1'b1;
      if (expect_out) sb.push_back('{l: el, r: er, cyc: cnt + 6});
      @(negedge clk);
      bands_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic write_gain(input logic [5:0] sel, input logic [15:0] data);
      @(negedge clk);
      gain_select  = sel;
      gain_wr_data = data;
      gain_wr_en   = 1'b1;
      @(negedge clk);
      gain_wr_en   = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
   endtask

   initial begin
      logic [NB-1:0][47:0] zero, one16, pos_all, neg_all, one1, neg1;
      zero    = '0;
      one16   = '0; one16[0] = 48'h0000_0010_0000;
      one1    = '0; one1[0]  = 48'h0000_0001_0000;
      neg1    = '0; neg1[0]  = 48'hFFFF_FFFF_0000;
      for (int i = 0; i < int'(NB); i++) begin
         pos_all[i] = 48'h3FFF_FFFF_0000;
         neg_all[i] = 48'hC000_0000_0000;
      end

      reset_n = 1'b0; audio_en = 1'b1; bands_valid = 1'b0;
      l_bands = '0; r_bands = '0; gain_wr_en = 1'b0; gain_select = 6'd0;
      gain_wr_data = '0; flag_clr = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_l_out", 32'(l_data_out), 32'd0);
      chk("rst_r_out", 32'(r_data_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sat", 32'(sat_flag), 32'd0);
      chk("rst_overrun", 32'(overrun_flag), 32'd0);
      chk("rst_test_data", 32'(test_data), 32'h4000);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Unity gain, single band
      issue(one16, zero, 1'b1, 24'h000020, 24'h000000);
      chk("busy_in_mac", 32'(busy), 32'd1);
      wait_done();
      chk("sat_after_small", 32'(sat_flag), 32'd0);

      // Positive and negative saturation
      issue(pos_all, pos_all, 1'b1, 24'h7FFFFF, 24'h7FFFFF);
      wait_done();
      chk("sat_pos", 32'(sat_flag), 32'd1);
      pulse_clr();
      chk("sat_clr", 32'(sat_flag), 32'd0);
      issue(neg_all, neg_all, 1'b1, 24'h800000, 24'h800000);
      wait_done();
      chk("sat_neg", 32'(sat_flag), 32'd1);
      pulse_clr();

      // Rounding: +0.5 rounds up, -0.5 rounds to zero
      write_gain(6'd0, 16'h1000);
      chk("test_data_1000", 32'(test_data), 32'h1000);
      issue(one1, neg1, 1'b1, 24'h000001, 24'h000000);
      wait_done();
      write_gain(6'd0, 16'h0000);
      issue(one1, one1, 1'b1, 24'h000000, 24'h000000);
      wait_done();
      // Out-of-range write is ignored and reads back zero
      write_gain(6'd5, 16'h1234);
      chk("test_data_oob", 32'(test_data), 32'h0000);
      @(negedge clk); gain_select = 6'd0;
      @(negedge clk);
      chk("gain0_kept", 32'(test_data), 32'h0000);

      // Overrun: second strobe two clocks later is dropped
      write_gain(6'd0, 16'h4000);
      issue(one16, one16, 1'b1, 24'h000020, 24'h000020);
      @(negedge clk); bands_valid = 1'b1;
      @(negedge clk); bands_valid = 1'b0;
      chk("overrun_set", 32'(overrun_flag), 32'd1);
      bands_valid = 1'b1; flag_clr = 1'b1;
      @(negedge clk); bands_valid = 1'b0; flag_clr = 1'b0;
      chk("overrun_set_wins", 32'(overrun_flag), 32'd1);
      wait_done();
      pulse_clr();
      chk("overrun_clr", 32'(overrun_flag), 32'd0);

      // Gain write during MAC: shadow used now, live gain next sample
      issue(one16, zero, 1'b1, 24'h000020, 24'h000000);
      write_gain(6'd0, 16'h2000);
      chk("test_data_live", 32'(test_data), 32'h2000);
      wait_done();
      issue(one16, zero, 1'b1, 24'h000010, 24'h000000);
      wait_done();

      // audio_en low mid-MAC aborts without a pulse; outputs retained
      issue(pos_all, pos_all, 1'b0, 24'h0, 24'h0);
      audio_en = 1'b0;
      @(negedge clk); audio_en = 1'b1;
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (8) @(negedge clk);
      chk("abort_l_hold", 32'(l_data_out), 32'h000010);
      chk("abort_sat", 32'(sat_flag), 32'd0);
      issue(one16, zero, 1'b1, 24'h000010, 24'h000000);
      wait_done();

      // Reset mid-MAC: no pulse, outputs and gains back to reset values
      issue(one16, one16, 1'b0, 24'h0, 24'h0);
      @(negedge clk); reset_n = 1'b0;
      #1;
      chk("mid_rst_l", 32'(l_data_out), 32'd0);
      chk("mid_rst_r", 32'(r_data_out), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_test_data", 32'(test_data), 32'h4000);
      repeat (2) @(negedge clk); reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_gain0", 32'(test_data), 32'h4000);
      chk("final_drain", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eq_band_mixer.md
EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 4, meaning number of FIR band outputs per channel (1..16).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port audio_en, input, 1, synchronous enable; low forces IDLE.
REQ-005 SHALL have port bands_valid, input, 1, one-clock strobe marking l_bands/r_bands valid.
REQ-006 SHALL have ports l_bands and r_bands, input, [47:0] x NUM_BANDS, signed Q2.38 FIR band results.
REQ-007 SHALL have port gain_wr_en, input, 1, one-clock gain write strobe.
REQ-008 SHALL have port gain_select, input, 6, band index addressed by write and test readback.
REQ-009 SHALL have port gain_wr_data, input, 16, signed Q2.14 gain.
REQ-010 SHALL have ports l_data_out and r_data_out, output, 24, signed Q1.23 mixed samples.
REQ-011 SHALL have port data_out_valid, output, 1, one-clock strobe marking outputs valid.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have ports sat_flag and overrun_flag, output, 1 each, sticky status bits.
REQ-014 SHALL have port flag_clr, input, 1, synchronous clear of both sticky flags.
REQ-015 SHALL have port test_data, output, 16, live gain register addressed by gain_select.

Function
REQ-016 SHALL hold one live gain register per band; gain_wr_en writes gain_wr_data to band gain_select when gain_select < NUM_BANDS, and ignores the write otherwise.
REQ-017 SHALL run FSM states IDLE -> MAC -> ROUND -> OUT -> IDLE.
REQ-018 In IDLE, bands_valid with audio_en high SHALL snapshot all band inputs and copy the live gains into shadow registers; next state MAC.
REQ-019 MAC SHALL process one band per clock, index 0..NUM_BANDS-1, with the L and R lanes running in parallel, then go to ROUND.
REQ-020 Per band, the block SHALL compute the 32-bit operand band[47:16], form a signed 48-bit product with the shadow gain, and sign-extend it into a 52-bit accumulator that is cleared at snapshot.
REQ-021 ROUND SHALL add 2^12 to the accumulator, arithmetic-shift it right by 13, and saturate the result to [-2^23, 2^23-1]; any clip SHALL set sat_flag.
REQ-022 OUT SHALL register l_data_out and r_data_out and pulse data_out_valid for exactly one clock, with latency NUM_BANDS+2 clocks from bands_valid; the data outputs SHALL hold until the next OUT.
REQ-023 bands_valid while busy SHALL be dropped, set overrun_flag, and leave the current computation unaffected.
REQ-024 A gain write during MAC SHALL update the live register only; the current sample SHALL use the shadow gains.
REQ-025 When flag_clr and a new flag-setting event occur in the same clock, the flag SHALL end up set.
REQ-026 audio_en low SHALL return the FSM to IDLE next clock, suppress data_out_valid, and clear the accumulators; gains, outputs and flags SHALL be retained.

Reset
REQ-027 On reset_n low, the FSM SHALL go to IDLE, band index and accumulators SHALL clear, l_data_out and r_data_out SHALL be 0, data_out_valid, busy, sat_flag and overflow_flag-related overrun_flag SHALL be 0, and all gains SHALL be 16'h4000 (unity).
REQ-028 Reset asserted mid-MAC SHALL abort with no data_out_valid pulse.

Structure
REQ-029 Package eq_pkg SHALL hold NUM_BANDS_MAX, UNITY_GAIN = 16'h4000, ROUND_SHIFT = 13, the width constants (48/32/16/52/24), and the FSM state enum.
REQ-030 Sub-module eq_mac_lane SHALL implement one channel's multiply, accumulate, round and saturate; it SHALL be instanced twice (L and R).

Verification
REQ-031 Unity gains, l_bands[0]=48'h0000_0010_0000, all other bands 0 -> l_data_out=24'h000020 and r_data_out=0, with valid exactly 6 clocks after bands_valid.
REQ-032 All four bands = 48'h3FFF_FFFF_0000 -> 24'h7FFFFF and sat_flag=1; all four bands = 48'hC000_0000_0000 -> 24'h800000.
REQ-033 Gain band0 = 16'h1000, l_bands[0]=48'h0000_0001_0000 -> l_data_out=24'h000001 (half rounds up); with gain 16'h0000 -> 0.
REQ-034 Second bands_valid 2 clocks after the first -> exactly one data_out_valid and overrun_flag=1; flag_clr -> 0.
REQ-035 Gain write to band0 during MAC -> current output uses the old gain, the next sample uses the new gain, and test_data shows the new value immediately.
REQ-036 reset_n low during MAC -> no valid pulse, outputs 0, test_data=16'h4000.
